// File: rtl/ysyx_25060170_lsu_bus.sv
// Load/store unit bridging EX and WB over a valid/ready memory bus.
// One access in flight; lane steering, extension and fault reporting.
module ysyx_25060170_lsu_bus #(
    parameter int XLEN     = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ls_ready,
    input  logic [3:0]        ls_ctl,
    input  logic [XLEN-1:0]   alu_res,
    input  logic [XLEN-1:0]   store_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [AW-1:0]     mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err,
    output logic              ls_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   ls_data_o,
    output logic              ls_exc,
    output logic [2:0]        ls_exc_cause,
    output logic [XLEN-1:0]   ls_data_forward
);

    localparam int SW = XLEN / 8;
    localparam int LB = $clog2(SW);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] MW = CW'(MAX_WAIT);

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_MISAL = 3'd1;
    localparam logic [2:0] C_BUS   = 3'd2;
    localparam logic [2:0] C_TMO   = 3'd3;
    localparam logic [2:0] C_SIZE  = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        lctl_q, lctl_d;
    logic              ld_q, ld_d;
    logic [LB-1:0]     off_q, off_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [2:0]        cause_q, cause_d;
    logic              exc_q, exc_d;
    logic              rqv_q, rqv_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;

    logic              is_load;
    logic              is_store;
    logic              is_lwu;
    logic [1:0]        sz;
    logic              illegal;
    logic              misal;
    logic [SW-1:0]     strb_base;
    logic [AW-1:0]     ea;
    logic [XLEN-1:0]   rsh;

    function automatic logic [XLEN-1:0] load_ext(
        input logic [2:0]      c,
        input logic [XLEN-1:0] w
    );
        logic [XLEN-1:0] r;
        r = '0;
        case (c)
            3'b001:  r = XLEN'($signed(w[7:0]));
            3'b010:  r = XLEN'($signed(w[15:0]));
            3'b011:  r = XLEN'($signed(w[31:0]));
            3'b100:  r = w;
            3'b101:  r = XLEN'(w[7:0]);
            3'b110:  r = XLEN'(w[15:0]);
            3'b111:  r = XLEN'(w[31:0]);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Op decode of the EX-presented control word
    always_comb begin
        is_load  = ls_ctl[3] && (ls_ctl[2:0] != 3'b000);
        is_store = 1'b0;
        is_lwu   = is_load && (ls_ctl[2:0] == 3'b111);
        sz       = 2'd0;
        if (is_load) begin
            unique case (1'b1)
                ls_ctl[2:0] == 3'b100: sz = 2'd3;
                ls_ctl[1:0] == 2'b01:  sz = 2'd0;
                ls_ctl[1:0] == 2'b10:  sz = 2'd1;
                ls_ctl[1:0] == 2'b11:  sz = 2'd2;
                default:               sz = 2'd0;
            endcase
        end else begin
            unique case (ls_ctl)
                4'b0001: begin is_store = 1'b1; sz = 2'd0; end
                4'b0010: begin is_store = 1'b1; sz = 2'd1; end
                4'b0100: begin is_store = 1'b1; sz = 2'd2; end
                4'b0101: begin is_store = 1'b1; sz = 2'd3; end
                default: begin is_store = 1'b0; sz = 2'd0; end
            endcase
        end
    end

    always_comb begin
        illegal = (XLEN == 32) && ((sz == 2'd3) || is_lwu);
        unique case (sz)
            2'd0: misal = 1'b0;
            2'd1: misal = alu_res[0];
            2'd2: misal = alu_res[1:0] != 2'b00;
            2'd3: misal = alu_res[2:0] != 3'b000;
        endcase
        unique case (sz)
            2'd0: strb_base = SW'(8'h01);
            2'd1: strb_base = SW'(8'h03);
            2'd2: strb_base = SW'(8'h0F);
            2'd3: strb_base = '1;
        endcase
    end

    assign ea  = AW'(alu_res);
    assign rsh = mem_rsp_rdata >> {off_q, 3'b000};

    always_comb begin
        state_d = state_q;
        lctl_d  = lctl_q;
        ld_d    = ld_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        cause_d = cause_q;
        rqv_d   = rqv_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    lctl_d  = ls_ctl[2:0];
                    ld_d    = is_load;
                    off_d   = alu_res[LB-1:0];
                    cause_d = C_NONE;
                    if (!is_load && !is_store) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        data_d  = alu_res;
                    end else if (illegal) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        data_d  = '0;
                        cause_d = C_SIZE;
                    end else if (misal) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        data_d  = '0;
                        cause_d = C_MISAL;
                    end else begin
                        state_d = REQ;
                        rqv_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {ea[AW-1:LB], {LB{1'b0}}};
                        wdata_d = is_store
                                ? store_data << {alu_res[LB-1:0], 3'b000}
                                : '0;
                        wstrb_d = is_store
                                ? strb_base << alu_res[LB-1:0]
                                : '0;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    rqv_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A response in the timeout cycle still completes normally
                if (mem_rsp_valid) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    if (mem_rsp_err) begin
                        cause_d = C_BUS;
                        data_d  = '0;
                    end else begin
                        cause_d = C_NONE;
                        data_d  = ld_q ? load_ext(lctl_q, rsh) : '0;
                    end
                end else if ((MAX_WAIT != 0) && (cnt_d == MW)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    cause_d = C_TMO;
                    data_d  = '0;
                end
            end
            DONE: begin
                if (wb_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase

        exc_d = cause_d != C_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lctl_q  <= '0;
            ld_q    <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cause_q <= C_NONE;
            exc_q   <= 1'b0;
            rqv_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            lctl_q  <= lctl_d;
            ld_q    <= ld_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cause_q <= cause_d;
            exc_q   <= exc_d;
            rqv_q   <= rqv_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign ls_ready        = state_q == IDLE;
    assign ls_data_forward = alu_res;
    assign mem_req_valid   = rqv_q;
    assign mem_req_we      = we_q;
    assign mem_req_addr    = addr_q;
    assign mem_req_wdata   = wdata_q;
    assign mem_req_wstrb   = wstrb_q;
    assign ls_valid        = valid_q;
    assign ls_data_o       = data_q;
    assign ls_exc          = exc_q;
    assign ls_exc_cause    = cause_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu_bus.sv
// Directed bench: 32-bit LSU with short timeout plus a 64-bit instance.
// Expected values are hand-computed constants.
module tb_ysyx_25060170_lsu_bus;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_exv = 0, a_rdy = 0, a_rv = 0, a_err = 0, a_wbr = 1;
    logic [3:0]  a_ctl = 0;
    logic [31:0] a_alu = 0, a_sd = 0, a_rd = 0;
    logic        a_lsr, a_rqv, a_we, a_lsv, a_exc;
    logic [31:0] a_addr, a_wd, a_data, a_fwd;
    logic [3:0]  a_strb;
    logic [2:0]  a_cause;

    logic        b_exv = 0, b_rdy = 0, b_rv = 0, b_err = 0, b_wbr = 1;
    logic [3:0]  b_ctl = 0;
    logic [63:0] b_alu = 0, b_sd = 0, b_rd = 0;
    logic        b_lsr, b_rqv, b_we, b_lsv, b_exc;
    logic [31:0] b_addr;
    logic [63:0] b_wd, b_data, b_fwd;
    logic [7:0]  b_strb;
    logic [2:0]  b_cause;

    ysyx_25060170_lsu_bus #(.XLEN(32), .AW(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(a_exv), .ls_ready(a_lsr),
        .ls_ctl(a_ctl), .alu_res(a_alu), .store_data(a_sd),
        .mem_req_valid(a_rqv), .mem_req_ready(a_rdy), .mem_req_we(a_we),
        .mem_req_addr(a_addr), .mem_req_wdata(a_wd), .mem_req_wstrb(a_strb),
        .mem_rsp_valid(a_rv), .mem_rsp_rdata(a_rd), .mem_rsp_err(a_err),
        .ls_valid(a_lsv), .wb_ready(a_wbr), .ls_data_o(a_data),
        .ls_exc(a_exc), .ls_exc_cause(a_cause), .ls_data_forward(a_fwd)
    );

    ysyx_25060170_lsu_bus #(.XLEN(64), .AW(32), .MAX_WAIT(255)) dut64 (
        .clk(clk), .rst(rst), .ex_valid(b_exv), .ls_ready(b_lsr),
        .ls_ctl(b_ctl), .alu_res(b_alu), .store_data(b_sd),
        .mem_req_valid(b_rqv), .mem_req_ready(b_rdy), .mem_req_we(b_we),
        .mem_req_addr(b_addr), .mem_req_wdata(b_wd), .mem_req_wstrb(b_strb),
        .mem_rsp_valid(b_rv), .mem_rsp_rdata(b_rd), .mem_rsp_err(b_err),
        .ls_valid(b_lsv), .wb_ready(b_wbr), .ls_data_o(b_data),
        .ls_exc(b_exc), .ls_exc_cause(b_cause), .ls_data_forward(b_fwd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] d);
        a_ctl = c;
        a_alu = a;
        a_sd  = d;
        a_exv = 1'b1;
        step();
        a_exv = 1'b0;
    endtask

    task automatic finish_mem(input logic [31:0] rd, input logic err);
        a_rdy = 1'b1;
        step();
        a_rdy = 1'b0;
        chk("req_drop", {63'd0, a_rqv}, 64'd0);
        a_rv  = 1'b1;
        a_rd  = rd;
        a_err = err;
        step();
        a_rv  = 1'b0;
        a_err = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic [31:0] d,
                            input logic [2:0] c);
        chk({tag, "_valid"}, {63'd0, a_lsv}, 64'd1);
        chk({tag, "_data"}, {32'd0, a_data}, {32'd0, d});
        chk({tag, "_cause"}, {61'd0, a_cause}, {61'd0, c});
        chk({tag, "_exc"}, {63'd0, a_exc}, {63'd0, (c != 3'd0)});
        step();
        chk({tag, "_idle"}, {62'd0, a_lsv, a_lsr}, 64'd1);
    endtask

    initial begin
        step();
        step();
        chk("rst_ready", {63'd0, a_lsr}, 64'd1);
        chk("rst_outs", {60'd0, a_lsv, a_rqv, a_we, a_exc}, 64'd0);
        chk("rst_data", {32'd0, a_data}, 64'd0);
        chk("rst_req", {a_addr, a_wd}, 64'd0);
        chk("rst_strb_cause", {57'd0, a_strb, a_cause}, 64'd0);
        rst = 1'b0;
        step();

        // sb with ready held low for 5 cycles
        start_op(4'b0001, 32'h8000_0003, 32'h0000_00AB);
        for (int i = 0; i < 5; i++) step();
        chk("sb_valid", {62'd0, a_rqv, a_we}, 64'd3);
        chk("sb_addr", {32'd0, a_addr}, 64'h8000_0000);
        chk("sb_wdata", {32'd0, a_wd}, 64'hAB00_0000);
        chk("sb_wstrb", {60'd0, a_strb}, 64'h8);
        chk("sb_busy", {63'd0, a_lsr}, 64'd0);
        finish_mem(32'hDEAD_BEEF, 1'b0);
        chk_done("sb", 32'h0, 3'd0);

        start_op(4'b0010, 32'h8000_0002, 32'h1234_BEEF);
        chk("sh_wdata", {32'd0, a_wd}, 64'hBEEF_0000);
        chk("sh_wstrb", {60'd0, a_strb}, 64'hC);
        finish_mem(32'h0, 1'b0);
        chk_done("sh", 32'h0, 3'd0);

        start_op(4'b0100, 32'h8000_0004, 32'hCAFE_F00D);
        chk("sw_req", {a_addr, a_wd}, 64'h8000_0004_CAFE_F00D);
        chk("sw_wstrb", {60'd0, a_strb}, 64'hF);
        finish_mem(32'h0, 1'b0);
        chk_done("sw", 32'h0, 3'd0);

        start_op(4'b1010, 32'h8000_0002, 32'h0);
        chk("lh_req", {30'd0, a_rqv, a_we, a_addr}, 64'h2_8000_0000);
        chk("lh_wstrb", {60'd0, a_strb}, 64'h0);
        finish_mem(32'h8001_1234, 1'b0);
        chk_done("lh", 32'hFFFF_8001, 3'd0);

        start_op(4'b1110, 32'h8000_0002, 32'h0);
        finish_mem(32'h8001_1234, 1'b0);
        chk_done("lhu", 32'h0000_8001, 3'd0);

        start_op(4'b1001, 32'h8000_0001, 32'h0);
        finish_mem(32'h8001_1234, 1'b0);
        chk_done("lb", 32'h0000_0012, 3'd0);

        start_op(4'b1001, 32'h8000_0003, 32'h0);
        finish_mem(32'h8001_1234, 1'b0);
        chk_done("lb_neg", 32'hFFFF_FF80, 3'd0);

        start_op(4'b1101, 32'h8000_0003, 32'h0);
        finish_mem(32'h8001_1234, 1'b0);
        chk_done("lbu", 32'h0000_0080, 3'd0);

        start_op(4'b1011, 32'h8000_0008, 32'h0);
        finish_mem(32'h8001_1234, 1'b0);
        chk_done("lw", 32'h8001_1234, 3'd0);

        // Faults complete one cycle after accept with no bus request
        start_op(4'b1011, 32'h8000_0002, 32'h0);
        chk("lw_mis_noreq", {63'd0, a_rqv}, 64'd0);
        chk_done("lw_mis", 32'h0, 3'd1);

        start_op(4'b0010, 32'h8000_0001, 32'h55);
        chk("sh_mis_noreq", {63'd0, a_rqv}, 64'd0);
        chk_done("sh_mis", 32'h0, 3'd1);

        start_op(4'b1100, 32'h8000_0000, 32'h0);
        chk("ld32_noreq", {63'd0, a_rqv}, 64'd0);
        chk_done("ld32", 32'h0, 3'd4);

        start_op(4'b1111, 32'h8000_0000, 32'h0);
        chk_done("lwu32", 32'h0, 3'd4);

        start_op(4'b0000, 32'h1234_5678, 32'h0);
        chk("fwd", {32'd0, a_fwd}, 64'h1234_5678);
        chk_done("alu", 32'h1234_5678, 3'd0);

        start_op(4'b1011, 32'h8000_0010, 32'h0);
        finish_mem(32'h1111_1111, 1'b1);
        chk_done("buserr", 32'h0, 3'd2);

        // Timeout after four WAIT cycles, then a stray response in IDLE
        start_op(4'b1011, 32'h8000_0020, 32'h0);
        a_rdy = 1'b1;
        step();
        a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("tmo_pending", {63'd0, a_lsv}, 64'd0);
        step();
        chk_done("tmo", 32'h0, 3'd3);
        a_rv = 1'b1;
        a_rd = 32'h7777_7777;
        step();
        a_rv = 1'b0;
        chk("late_rsp", {62'd0, a_lsv, a_lsr}, 64'd1);

        // WB stall holds the result
        a_wbr = 1'b0;
        start_op(4'b0000, 32'hCAFE_0001, 32'h0);
        for (int i = 0; i < 3; i++) step();
        chk("stall_hold", {31'd0, a_lsv, a_data}, 64'h1_CAFE_0001);
        chk("stall_busy", {63'd0, a_lsr}, 64'd0);
        a_wbr = 1'b1;
        step();
        chk("stall_rel", {62'd0, a_lsv, a_lsr}, 64'd1);

        // Reset while waiting for a response
        start_op(4'b1011, 32'h8000_0040, 32'h0);
        a_rdy = 1'b1;
        step();
        a_rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_ready", {63'd0, a_lsr}, 64'd1);
        chk("rstw_outs", {60'd0, a_lsv, a_rqv, a_we, a_exc}, 64'd0);
        chk("rstw_addr", {32'd0, a_addr}, 64'd0);
        a_rv = 1'b1;
        a_rd = 32'h1;
        step();
        a_rv = 1'b0;
        chk("rstw_norsp", {63'd0, a_lsv}, 64'd0);

        // 64-bit instance: full-word ld and upper-lane sb
        b_ctl = 4'b1100;
        b_alu = 64'h8000_0008;
        b_exv = 1'b1;
        step();
        b_exv = 1'b0;
        chk("ld64_addr", {31'd0, b_rqv, b_addr}, 64'h1_8000_0008);
        b_rdy = 1'b1;
        step();
        b_rdy = 1'b0;
        b_rv = 1'b1;
        b_rd = 64'h1122_3344_5566_7788;
        step();
        b_rv = 1'b0;
        chk("ld64_valid", {60'd0, b_lsv, b_cause}, 64'h8);
        chk("ld64_data", b_data, 64'h1122_3344_5566_7788);
        step();

        b_ctl = 4'b0001;
        b_alu = 64'h8000_0005;
        b_sd  = 64'hAB;
        b_exv = 1'b1;
        step();
        b_exv = 1'b0;
        chk("sb64_wdata", b_wd, 64'h0000_AB00_0000_0000);
        chk("sb64_wstrb", {56'd0, b_strb}, 64'h20);
        chk("sb64_addr", {32'd0, b_addr}, 64'h8000_0000);
        b_rdy = 1'b1;
        step();
        b_rdy = 1'b0;
        b_rv = 1'b1;
        step();
        b_rv = 1'b0;
        chk("sb64_done", {b_lsv, b_data[62:0]}, 64'h8000_0000_0000_0000);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
